// File: rtl/vram_sprite_pkg.sv
// Shared types, default geometry and the line-mirror helper for the sprite line fetcher.
package vram_sprite_pkg;

  localparam int unsigned PIXEL_W_DEF         = 8;
  localparam int unsigned PIXELS_PER_WORD_DEF = 2;
  localparam int unsigned WORDS_PER_LINE_DEF  = 16;
  localparam int unsigned LINE_ADDR_W_DEF     = 11;

  // Upper bound on an assembled line; the mirror helper works on this width.
  localparam int unsigned LINE_MAX_W  = 1024;
  localparam int unsigned LINE_MAX_IW = $clog2(LINE_MAX_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Reverse pixel order across the whole line when flip is set.
  // Reversing words and swapping pixels inside each word is the same as a
  // full pixel-order reversal, so the word structure does not matter here.
  function automatic logic [LINE_MAX_W-1:0] mirror_line(
    input logic [LINE_MAX_W-1:0] line,
    input logic                  flip,
    input int unsigned           pix_w,
    input int unsigned           n_pix
  );
    logic [LINE_MAX_W-1:0] res;
    res = line;
    if (flip) begin
      res = '0;
      for (int unsigned i = 0; i < LINE_MAX_W; i++) begin
        if (i < pix_w * n_pix) begin
          res[LINE_MAX_IW'((n_pix - 1 - i / pix_w) * pix_w + i % pix_w)] = line[LINE_MAX_IW'(i)];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vram_sprite_bram.sv
// Simple dual-port RAM: one write port, one read-first synchronous read port.
module vram_sprite_bram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write and read in one process: a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/vram_sprite_line_fetcher.sv
// Sprite pattern memory with a sequential line-fetch engine and optional horizontal mirror.
module vram_sprite_line_fetcher
  import vram_sprite_pkg::*;
#(
  parameter  int unsigned PIXEL_W         = PIXEL_W_DEF,
  parameter  int unsigned PIXELS_PER_WORD = PIXELS_PER_WORD_DEF,
  parameter  int unsigned WORDS_PER_LINE  = WORDS_PER_LINE_DEF,
  parameter  int unsigned LINE_ADDR_W     = LINE_ADDR_W_DEF,
  localparam int unsigned WORD_W          = PIXEL_W * PIXELS_PER_WORD,
  localparam int unsigned WOFF_W          = $clog2(WORDS_PER_LINE),
  localparam int unsigned LINE_W          = WORD_W * WORDS_PER_LINE,
  localparam int unsigned ADDR_W          = LINE_ADDR_W + WOFF_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [LINE_ADDR_W-1:0] i_req_line,
  input  logic                   i_req_flip,
  output logic                   o_line_valid,
  input  logic                   i_line_ready,
  output logic [LINE_W-1:0]      o_line_data
);

  localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORDS_PER_LINE - 1);
  localparam int unsigned       N_PIX     = PIXELS_PER_WORD * WORDS_PER_LINE;

  fetch_state_e           r_state;
  logic [LINE_ADDR_W-1:0] r_req_line;
  logic                   r_flip;
  logic [WOFF_W-1:0]      r_cnt;
  logic                   r_issuing;
  logic                   r_pend_valid;
  logic [WOFF_W-1:0]      r_pend_slot;
  logic [LINE_W-1:0]      r_line;
  logic                   r_req_ready;
  logic                   r_line_valid;

  logic                   w_rd_en;
  logic [ADDR_W-1:0]      w_rd_addr;
  logic [WORD_W-1:0]      w_rd_data;

  // Read address: offset field never carries into the line field.
  assign w_rd_en   = (r_state == FETCH) && r_issuing;
  assign w_rd_addr = {r_req_line, r_cnt};

  vram_sprite_bram #(
    .DATA_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk       (clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Fetch FSM: issue one word per cycle, land each word one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_line   <= '0;
      r_flip       <= 1'b0;
      r_cnt        <= '0;
      r_issuing    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_slot  <= '0;
      r_line       <= '0;
      r_req_ready  <= 1'b1;
      r_line_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_req_line   <= i_req_line;
            r_flip       <= i_req_flip;
            r_cnt        <= '0;
            r_issuing    <= 1'b1;
            r_pend_valid <= 1'b0;
            r_req_ready  <= 1'b0;
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          if (r_issuing) begin
            r_pend_valid <= 1'b1;
            r_pend_slot  <= r_cnt;
            if (r_cnt == LAST_WORD) begin
              r_issuing <= 1'b0;
            end else begin
              r_cnt <= r_cnt + WOFF_W'(1);
            end
          end else begin
            r_pend_valid <= 1'b0;
          end
          if (r_pend_valid) begin
            for (int s = 0; s < int'(WORDS_PER_LINE); s++) begin
              if (r_pend_slot == WOFF_W'(s)) begin
                r_line[(int'(WORDS_PER_LINE) - 1 - s) * int'(WORD_W) +: WORD_W] <= w_rd_data;
              end
            end
            if (r_pend_slot == LAST_WORD) begin
              r_line_valid <= 1'b1;
              r_state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (i_line_ready) begin
            r_line_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_line_valid = r_line_valid;
  // Mirror is applied on the way out, from the flag latched with the request.
  assign o_line_data  = LINE_W'(mirror_line(LINE_MAX_W'(r_line), r_flip, PIXEL_W, N_PIX));

endmodule

// File: tb/tb_vram_sprite_line_fetcher.sv
// Directed bench for vram_sprite_line_fetcher at default geometry.
module tb_vram_sprite_line_fetcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_wr_en;
  logic [14:0]  i_wr_addr;
  logic [15:0]  i_wr_data;
  logic         i_req_valid;
  logic         o_req_ready;
  logic [10:0]  i_req_line;
  logic         i_req_flip;
  logic         o_line_valid;
  logic         i_line_ready;
  logic [255:0] o_line_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_sprite_line_fetcher dut (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_line   (i_req_line),
    .i_req_flip   (i_req_flip),
    .o_line_valid (o_line_valid),
    .i_line_ready (i_line_ready),
    .o_line_data  (o_line_data)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [14:0] a, input logic [15:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    @(negedge clk);
    i_wr_en   = 1'b0;
  endtask

  // Leaves the bench at the negedge after the acceptance edge.
  task automatic fetch_start(input logic [10:0] l, input logic f);
    i_req_valid = 1'b1;
    i_req_line  = l;
    i_req_flip  = f;
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  // Counts edges since acceptance until line_valid is seen, bounded.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (o_line_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_line(input string tag);
    i_line_ready = 1'b1;
    @(negedge clk);
    i_line_ready = 1'b0;
    check({tag, "_valid_low"}, 256'(o_line_valid), 256'(1'b0));
    check({tag, "_ready_high"}, 256'(o_req_ready), 256'(1'b1));
  endtask

  initial begin
    logic [255:0] exp5, exp5f, exp7, exp7c, exp0;
    logic [255:0] hold_data;
    logic         hold_ok;
    int           lat;

    exp5 = '0; exp5f = '0; exp7 = '0; exp7c = '0; exp0 = '0;
    for (int w = 0; w < 16; w++) begin
      exp5  = {exp5[239:0], 16'h0100 + 16'(w)};
      exp0  = {exp0[239:0], 16'h1100 + 16'(w)};
      exp7  = {exp7[239:0], (w == 15) ? 16'hBEEF : 16'h0700 + 16'(w)};
      exp7c = {exp7c[239:0], (w == 15) ? 16'hBEEF : (w == 3) ? 16'hDEAD : 16'h0700 + 16'(w)};
    end
    for (int w = 15; w >= 0; w--) begin
      exp5f = {exp5f[239:0], 8'(w), 8'h01};
    end

    reset        = 1'b1;
    i_wr_en      = 1'b0;
    i_wr_addr    = '0;
    i_wr_data    = '0;
    i_req_valid  = 1'b0;
    i_req_line   = '0;
    i_req_flip   = 1'b0;
    i_line_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", 256'(o_req_ready), 256'(1'b1));
    check("rst_line_valid", 256'(o_line_valid), 256'(1'b0));
    check("rst_line_data", o_line_data, 256'(0));

    for (int w = 0; w < 16; w++) begin
      write_word({11'd5, 4'(w)}, 16'h0100 + 16'(w));
      write_word({11'd7, 4'(w)}, 16'h0700 + 16'(w));
      write_word({11'd0, 4'(w)}, 16'h1100 + 16'(w));
    end

    // Plain fetch of line 5.
    fetch_start(11'd5, 1'b0);
    check("fetch_ready_low", 256'(o_req_ready), 256'(1'b0));
    wait_valid(0, lat);
    check("l5_latency", 256'(lat), 256'(17));
    check("l5_data", o_line_data, exp5);
    release_line("l5_rel");

    // Flipped fetch, then a long hold with an ignored request.
    fetch_start(11'd5, 1'b1);
    wait_valid(0, lat);
    check("l5f_latency", 256'(lat), 256'(17));
    check("l5f_data", o_line_data, exp5f);
    hold_data = o_line_data;
    hold_ok   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        i_req_valid = 1'b1;
        i_req_line  = 11'd0;
        i_req_flip  = 1'b0;
      end
      if (i == 6) i_req_valid = 1'b0;
      @(negedge clk);
      if (o_line_valid !== 1'b1 || o_line_data !== hold_data || o_req_ready !== 1'b0) hold_ok = 1'b0;
    end
    check("hold_stable", 256'(hold_ok), 256'(1'b1));
    release_line("hold_rel");
    repeat (3) @(negedge clk);
    check("no_queued_req", 256'(o_line_valid), 256'(1'b0));

    // Line 7: write to word 15 while word 3 is being issued.
    fetch_start(11'd7, 1'b0);
    repeat (3) @(negedge clk);
    write_word({11'd7, 4'd15}, 16'hBEEF);
    wait_valid(4, lat);
    check("l7_latency", 256'(lat), 256'(17));
    check("l7_late_write", o_line_data, exp7);
    release_line("l7_rel");

    // Line 7 again: write to word 3 in its own read cycle returns old word.
    fetch_start(11'd7, 1'b0);
    repeat (3) @(negedge clk);
    write_word({11'd7, 4'd3}, 16'hDEAD);
    wait_valid(4, lat);
    check("l7_read_first", o_line_data, exp7);
    release_line("l7b_rel");

    fetch_start(11'd7, 1'b0);
    wait_valid(0, lat);
    check("l7_write_landed", o_line_data, exp7c);
    release_line("l7c_rel");

    // Last RAM word, and line 0 left untouched.
    write_word(15'h7FFF, 16'hA5A5);
    fetch_start(11'd2047, 1'b0);
    wait_valid(0, lat);
    check("l2047_latency", 256'(lat), 256'(17));
    check("l2047_last_word", 256'(o_line_data[15:0]), 256'(16'hA5A5));
    release_line("l2047_rel");
    fetch_start(11'd0, 1'b0);
    wait_valid(0, lat);
    check("l0_untouched", o_line_data, exp0);
    release_line("l0_rel");

    // Reset four cycles into a fetch, then a clean refetch.
    fetch_start(11'd5, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 256'(o_req_ready), 256'(1'b1));
    check("midrst_valid", 256'(o_line_valid), 256'(1'b0));
    check("midrst_data", o_line_data, 256'(0));
    fetch_start(11'd5, 1'b0);
    wait_valid(0, lat);
    check("post_rst_latency", 256'(lat), 256'(17));
    check("post_rst_data", o_line_data, exp5);
    release_line("post_rst_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
